lvds_rx_aligner: RTL and testbench

Multi-lane receive back-end for the LVDS SerDes link, one clk_sys domain. Synchronises the per-frame strobe from the deserialiser and captures NUM_LANES parallel words. Each lane runs a training-pattern word-alignment state machine that rotates its word, then buffers aligned multi-lane words in a FIFO with a ready/valid output. Sits between the lane deserialisers and the system-side consumer.

---
 rtl/lvds_rx_pkg.sv | 17 +
 rtl/lvds_lane_align.sv | 92 +++++++++
 rtl/lvds_rx_aligner.sv | 135 +++++++++++++
 tb/tb_lvds_rx_aligner.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_rx_pkg.sv
// Shared definitions for the LVDS receive aligner: lane FSM states, default
// training word and the helper that sizes the per-lane slip counter.
package lvds_rx_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lane_state_e;

  localparam logic [7:0] DEFAULT_TRAIN_PATTERN = 8'hA5;

  function automatic int slipWidth(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/lvds_lane_align.sv
// One LVDS lane: rotates the captured word by the current slip, compares it
// against the training word and walks the HUNT/VERIFY/LOCKED alignment FSM.
module lvds_lane_align
  import lvds_rx_pkg::*;
#(
  parameter int                        PARALLEL_WIDTH = 8,
  parameter logic [PARALLEL_WIDTH-1:0] TRAIN_PATTERN  = PARALLEL_WIDTH'(DEFAULT_TRAIN_PATTERN),
  parameter int                        LOCK_COUNT     = 4,
  localparam int                       SLIP_W         = slipWidth(PARALLEL_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      eval_i,
  input  logic                      realign_i,
  input  logic [PARALLEL_WIDTH-1:0] word_i,
  output logic [PARALLEL_WIDTH-1:0] aligned_o,
  output logic                      locked_o,
  output logic [SLIP_W-1:0]         slip_o
);

  localparam int CNT_W = $clog2(LOCK_COUNT + 1);

  lane_state_e                 state_q;
  logic [SLIP_W-1:0]           slip_q;
  logic [SLIP_W-1:0]           slip_d;
  logic [CNT_W-1:0]            matchCnt_q;
  logic [CNT_W-1:0]            matchCnt_d;
  logic                        locked_q;
  logic [2*PARALLEL_WIDTH-1:0] doubled;
  logic                        match;

  // Shifting the word concatenated with itself gives a rotate-right by slip.
  assign doubled   = {word_i, word_i} >> slip_q;
  assign aligned_o = doubled[PARALLEL_WIDTH-1:0];
  assign match     = (aligned_o == TRAIN_PATTERN);

  always_comb begin
    slip_d     = (slip_q == SLIP_W'(PARALLEL_WIDTH - 1)) ? '0 : slip_q + SLIP_W'(1);
    matchCnt_d = matchCnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= HUNT;
      slip_q     <= '0;
      matchCnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (realign_i) begin
      // Re-hunting starts from the slip already found; counters are held.
      state_q  <= HUNT;
      locked_q <= 1'b0;
    end else if (eval_i) begin
      case (state_q)
        HUNT: begin
          if (match) begin
            matchCnt_q <= CNT_W'(1);
            if (LOCK_COUNT == 1) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              state_q <= VERIFY;
            end
          end else begin
            slip_q <= slip_d;
          end
        end
        VERIFY: begin
          if (match) begin
            matchCnt_q <= matchCnt_d;
            if (matchCnt_d == CNT_W'(LOCK_COUNT)) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end else begin
            state_q    <= HUNT;
            slip_q     <= slip_d;
            matchCnt_q <= '0;
          end
        end
        LOCKED: state_q <= LOCKED;
        default: begin
          state_q  <= HUNT;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign locked_o = locked_q;
  assign slip_o   = slip_q;

endmodule

// File: rtl/lvds_rx_aligner.sv
// Multi-lane LVDS receive back-end: frame-strobe synchroniser, word capture,
// per-lane alignment and a ready/valid output FIFO of aligned words.
module lvds_rx_aligner
  import lvds_rx_pkg::*;
#(
  parameter int                        PARALLEL_WIDTH = 8,
  parameter int                        NUM_LANES      = 2,
  parameter logic [PARALLEL_WIDTH-1:0] TRAIN_PATTERN  = PARALLEL_WIDTH'(DEFAULT_TRAIN_PATTERN),
  parameter int                        LOCK_COUNT     = 4,
  parameter int                        FIFO_DEPTH     = 8,
  localparam int                       SLIP_W         = slipWidth(PARALLEL_WIDTH),
  localparam int                       DATA_W         = NUM_LANES * PARALLEL_WIDTH
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           deserialized_word,
  input  logic                        rx_frame_pulse,
  input  logic                        realign,
  output logic [DATA_W-1:0]           rx_data_out,
  output logic                        rx_data_valid,
  input  logic                        rx_data_ready,
  output logic [NUM_LANES-1:0]        lane_locked,
  output logic                        all_locked,
  output logic [NUM_LANES*SLIP_W-1:0] slip_count,
  output logic                        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic              syncMeta_q;
  logic              sync_q;
  logic              syncDly_q;
  logic              strobe_q;
  logic              captureValid_q;
  logic [DATA_W-1:0] captureWord_q;
  logic [DATA_W-1:0] alignedWord;

  // Registering the edge detect puts the capture three edges after the first
  // sample of the pulse, while the deserialiser still holds the word.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      syncMeta_q     <= 1'b0;
      sync_q         <= 1'b0;
      syncDly_q      <= 1'b0;
      strobe_q       <= 1'b0;
      captureValid_q <= 1'b0;
      captureWord_q  <= '0;
    end else begin
      syncMeta_q     <= rx_frame_pulse;
      sync_q         <= syncMeta_q;
      syncDly_q      <= sync_q;
      strobe_q       <= sync_q & ~syncDly_q;
      captureValid_q <= strobe_q;
      if (strobe_q) begin
        captureWord_q <= deserialized_word;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    lvds_lane_align #(
      .PARALLEL_WIDTH(PARALLEL_WIDTH),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .LOCK_COUNT    (LOCK_COUNT)
    ) uLane (
      .clk_i    (clk_sys),
      .reset_i  (reset),
      .eval_i   (captureValid_q),
      .realign_i(realign),
      .word_i   (captureWord_q[g*PARALLEL_WIDTH +: PARALLEL_WIDTH]),
      .aligned_o(alignedWord[g*PARALLEL_WIDTH +: PARALLEL_WIDTH]),
      .locked_o (lane_locked[g]),
      .slip_o   (slip_count[g*SLIP_W +: SLIP_W])
    );
  end

  assign all_locked = &lane_locked;

  logic [DATA_W-1:0] fifoMem_q [FIFO_DEPTH];
  logic [AW-1:0]     wrPtr_q;
  logic [AW-1:0]     rdPtr_q;
  logic [AW:0]       count_q;
  logic [AW:0]       count_d;
  logic              overflow_q;
  logic              pushReq;
  logic              pushOk;
  logic              pop;
  logic              fifoFull;
  logic              fifoEmpty;

  // all_locked here is still the pre-evaluation value, so the word that
  // completes lock is never written.
  always_comb begin
    fifoFull  = (count_q == (AW+1)'(FIFO_DEPTH));
    fifoEmpty = (count_q == '0);
    pop       = ~fifoEmpty & rx_data_ready;
    pushReq   = captureValid_q & all_locked & ~realign;
    pushOk    = pushReq & (~fifoFull | pop);
    count_d   = count_q + (AW+1)'(pushOk) - (AW+1)'(pop);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pushOk) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      count_q <= count_d;
      if (realign) begin
        overflow_q <= 1'b0;
      end else if (pushReq & fifoFull & ~pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the output is masked to zero while empty.
  always_ff @(posedge clk_sys) begin
    if (pushOk) begin
      fifoMem_q[wrPtr_q] <= alignedWord;
    end
  end

  assign rx_data_valid = ~fifoEmpty;
  assign rx_data_out   = fifoEmpty ? '0 : fifoMem_q[rdPtr_q];
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_lvds_rx_aligner.sv
// Randomised self-checking bench for lvds_rx_aligner against a lane/FIFO
// reference model built from the alignment rules with plain arithmetic and a queue.
module tb_lvds_rx_aligner;

  localparam int         W   = 8;
  localparam int         L   = 2;
  localparam logic [7:0] TP  = 8'hA5;
  localparam int         LC  = 4;
  localparam int         D   = 8;
  localparam int         SW  = 3;

  logic            clk_sys = 1'b0;
  logic            reset = 1'b1;
  logic [L*W-1:0]  deserialized_word = '0;
  logic            rx_frame_pulse = 1'b0;
  logic            realign = 1'b0;
  logic [L*W-1:0]  rx_data_out;
  logic            rx_data_valid;
  logic            rx_data_ready = 1'b0;
  logic [L-1:0]    lane_locked;
  logic            all_locked;
  logic [L*SW-1:0] slip_count;
  logic            overflow;

  int testsRun = 0;
  int testsFailed = 0;
  int readyMode = 0;

  // Reference model: per lane slip, consecutive-match count and phase
  // (0 hunting, 1 verifying, 2 locked), plus the expected FIFO contents.
  int             mSlip [L];
  int             mCnt [L];
  int             mPhase [L];
  bit             mOverflow;
  logic [L*W-1:0] mQueue [$];

  lvds_rx_aligner #(
    .PARALLEL_WIDTH(W),
    .NUM_LANES     (L),
    .TRAIN_PATTERN (TP),
    .LOCK_COUNT    (LC),
    .FIFO_DEPTH    (D)
  ) dut (
    .clk_sys          (clk_sys),
    .reset            (reset),
    .deserialized_word(deserialized_word),
    .rx_frame_pulse   (rx_frame_pulse),
    .realign          (realign),
    .rx_data_out      (rx_data_out),
    .rx_data_valid    (rx_data_valid),
    .rx_data_ready    (rx_data_ready),
    .lane_locked      (lane_locked),
    .all_locked       (all_locked),
    .slip_count       (slip_count),
    .overflow         (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] rotRight(input logic [7:0] w, input int s);
    int v = int'(w);
    return 8'(((v >> s) | (v << (W - s))) & ((1 << W) - 1));
  endfunction

  function automatic logic [7:0] rotLeft(input logic [7:0] w, input int s);
    int v = int'(w);
    return 8'(((v << s) | (v >> (W - s))) & ((1 << W) - 1));
  endfunction

  function automatic bit modelAllLocked();
    bit r = 1'b1;
    for (int i = 0; i < L; i++) if (mPhase[i] != 2) r = 1'b0;
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < L; i++) begin
      mSlip[i] = 0; mCnt[i] = 0; mPhase[i] = 0;
    end
    mOverflow = 1'b0;
    mQueue.delete();
  endtask

  task automatic modelEval(input logic [L*W-1:0] word);
    bit             wasLocked = modelAllLocked();
    logic [L*W-1:0] aw;
    logic [7:0]     a;
    for (int i = 0; i < L; i++) begin
      a = rotRight(word[i*W +: W], mSlip[i]);
      aw[i*W +: W] = a;
      if (mPhase[i] == 0) begin
        if (a == TP) begin
          mCnt[i] = 1;
          mPhase[i] = (LC == 1) ? 2 : 1;
        end else mSlip[i] = (mSlip[i] + 1) % W;
      end else if (mPhase[i] == 1) begin
        if (a == TP) begin
          mCnt[i]++;
          if (mCnt[i] == LC) mPhase[i] = 2;
        end else begin
          mPhase[i] = 0; mCnt[i] = 0; mSlip[i] = (mSlip[i] + 1) % W;
        end
      end
    end
    if (wasLocked) begin
      if (mQueue.size() < D) mQueue.push_back(aw);
      else mOverflow = 1'b1;
    end
  endtask

  task automatic checkStatus(input string tag);
    logic [L*SW-1:0] es;
    logic [L-1:0]    el;
    for (int i = 0; i < L; i++) begin
      es[i*SW +: SW] = SW'(mSlip[i]);
      el[i] = (mPhase[i] == 2);
    end
    checkOutput({tag, ".slip"}, slip_count, es);
    checkOutput({tag, ".locked"}, lane_locked, el);
    checkOutput({tag, ".allLocked"}, all_locked, &el);
    checkOutput({tag, ".overflow"}, overflow, mOverflow);
  endtask

  // One frame: pulse raised before edge N, model evaluated at edge N+4.
  task automatic applyStimulus(input logic [L*W-1:0] word, input int len, input bit checkLat);
    @(negedge clk_sys);
    deserialized_word = word;
    rx_frame_pulse = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk_sys);
      if (c == 5) modelEval(word);
      #1;
      if (checkLat && c == 4) checkOutput("validBeforeWrite", rx_data_valid, 1'b0);
      if (checkLat && c == 5) checkOutput("validAfterWrite", rx_data_valid, 1'b1);
      if (c == 5) checkStatus("frame");
      @(negedge clk_sys);
      if (c == len) rx_frame_pulse = 1'b0;
    end
  endtask

  task automatic doRealign();
    @(negedge clk_sys);
    realign = 1'b1;
    @(posedge clk_sys);
    for (int i = 0; i < L; i++) mPhase[i] = 0;
    mOverflow = 1'b0;
    #1;
    @(negedge clk_sys);
    realign = 1'b0;
  endtask

  // Consumer: ready chosen per cycle, every accepted word checked against the model.
  initial begin
    logic [L*W-1:0] expWord;
    forever begin
      @(negedge clk_sys);
      case (readyMode)
        0:       rx_data_ready = 1'($urandom_range(0, 1));
        1:       rx_data_ready = 1'b1;
        default: rx_data_ready = 1'b0;
      endcase
      if (rx_data_valid && rx_data_ready) begin
        if (mQueue.size() == 0) checkOutput("popWhileModelEmpty", rx_data_valid, 1'b0);
        else begin
          expWord = mQueue.pop_front();
          checkOutput("dataOut", rx_data_out, expWord);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [L*W-1:0] trainWord;
    logic [L*W-1:0] rw;
    trainWord = {rotLeft(TP, 5), rotLeft(TP, 3)};
    modelReset();

    repeat (3) @(posedge clk_sys);
    #1;
    checkOutput("resetValid", rx_data_valid, 1'b0);
    checkOutput("resetData", rx_data_out, '0);
    checkOutput("resetLocked", lane_locked, '0);
    checkOutput("resetAllLocked", all_locked, 1'b0);
    checkOutput("resetSlip", slip_count, '0);
    checkOutput("resetOverflow", overflow, 1'b0);
    @(negedge clk_sys);
    reset = 1'b0;

    $display("[TB] training lanes with rotations 3 and 5");
    for (int f = 0; f < 30 && !modelAllLocked(); f++)
      applyStimulus(trainWord, $urandom_range(2, 6), 1'b0);
    checkOutput("trainSlip", slip_count, {3'd5, 3'd3});
    checkOutput("trainLocked", lane_locked, 2'b11);
    checkOutput("trainNoWrites", rx_data_valid, 1'b0);

    $display("[TB] locked data with latency checks");
    readyMode = 1;
    applyStimulus(16'h1234, 2, 1'b1);
    applyStimulus(16'h5678, 3, 1'b1);
    readyMode = 0;
    for (int f = 0; f < 12; f++) begin
      rw = 16'($urandom);
      applyStimulus(rw, $urandom_range(2, 6), 1'b0);
    end

    $display("[TB] long pulse gives one capture");
    readyMode = 1;
    repeat (20) @(negedge clk_sys);
    checkOutput("drainedBeforeLong", rx_data_valid, 1'b0);
    readyMode = 2;
    repeat (2) @(negedge clk_sys);
    rw = 16'($urandom);
    applyStimulus(rw, 6, 1'b0);
    checkOutput("longPulseStored", rx_data_valid, 1'b1);
    readyMode = 1;
    repeat (4) @(negedge clk_sys);
    checkOutput("longPulseSingle", rx_data_valid, 1'b0);

    $display("[TB] overflow with ready held low");
    readyMode = 2;
    repeat (2) @(negedge clk_sys);
    for (int f = 0; f < D + 1; f++) begin
      rw = 16'($urandom);
      applyStimulus(rw, $urandom_range(2, 6), 1'b0);
    end
    checkOutput("overflowSet", overflow, 1'b1);
    checkOutput("fullValid", rx_data_valid, 1'b1);
    readyMode = 1;
    repeat (D + 4) @(negedge clk_sys);
    checkOutput("drainValid", rx_data_valid, 1'b0);
    checkOutput("drainLeftInModel", mQueue.size(), 0);
    checkOutput("overflowSticky", overflow, 1'b1);

    $display("[TB] realign and verify mismatch");
    doRealign();
    checkOutput("realignLocked", lane_locked, 2'b00);
    checkOutput("realignOverflow", overflow, 1'b0);
    checkOutput("realignSlipHeld", slip_count, {3'd5, 3'd3});
    applyStimulus(trainWord, 3, 1'b0);
    applyStimulus(trainWord, 4, 1'b0);
    applyStimulus({rotLeft(TP, 5), rotLeft(TP, 3) ^ 8'h01}, 2, 1'b0);
    checkOutput("mismatchSlipLane0", slip_count[SW-1:0], 3'd4);
    checkOutput("mismatchLane0Hunt", lane_locked[0], 1'b0);
    for (int f = 0; f < 30 && !modelAllLocked(); f++)
      applyStimulus(trainWord, $urandom_range(2, 6), 1'b0);
    checkOutput("relockLocked", lane_locked, 2'b11);

    $display("[TB] reset with entries in the FIFO");
    readyMode = 2;
    for (int f = 0; f < 3; f++) begin
      rw = 16'($urandom);
      applyStimulus(rw, 2, 1'b0);
    end
    checkOutput("preResetValid", rx_data_valid, 1'b1);
    @(negedge clk_sys);
    reset = 1'b1;
    @(posedge clk_sys);
    modelReset();
    #1;
    checkOutput("midResetValid", rx_data_valid, 1'b0);
    checkOutput("midResetAllLocked", all_locked, 1'b0);
    checkOutput("midResetSlip", slip_count, '0);
    checkOutput("midResetData", rx_data_out, '0);
    @(negedge clk_sys);
    reset = 1'b0;
    readyMode = 0;
    applyStimulus(trainWord, 2, 1'b0);
    repeat (4) @(negedge clk_sys);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
